// File: rtl/ndp_pkg.sv
// Shared constants, width helpers and state encoding for the NDP unit datapath blocks.
package ndp_pkg;

  function automatic int unsigned ridx_width(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_ARR_HEIGHT = 4;
  localparam int unsigned DEF_ARR_WIDTH  = 4;
  localparam int unsigned DEF_SYS_HEIGHT = 1;
  localparam int unsigned DEF_SYS_WIDTH  = 64;

  localparam int unsigned ROWS     = DEF_SYS_HEIGHT * DEF_ARR_HEIGHT;
  localparam int unsigned ROW_BITS = DEF_SYS_WIDTH * DEF_ARR_WIDTH * DEF_WIDTH;
  localparam int unsigned MAT_BITS = ROWS * ROW_BITS;
  localparam int unsigned RIDX_W   = ridx_width(ROWS);

  // Drain / feeder FSM encoding
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

endpackage

// File: rtl/ndp_edge_det.sv
// Registered rising-edge detector; rise_c is high for the first cycle a level goes high.
module ndp_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/ndp_result_drain.sv
// Captures the NDP result matrix on calc_done_flag and streams it out one row per beat.
module ndp_result_drain
  import ndp_pkg::*;
#(
  parameter  int unsigned WIDTH      = DEF_WIDTH,
  parameter  int unsigned ARR_HEIGHT = DEF_ARR_HEIGHT,
  parameter  int unsigned ARR_WIDTH  = DEF_ARR_WIDTH,
  parameter  int unsigned SYS_HEIGHT = DEF_SYS_HEIGHT,
  parameter  int unsigned SYS_WIDTH  = DEF_SYS_WIDTH,
  localparam int unsigned NROWS      = SYS_HEIGHT * ARR_HEIGHT,
  localparam int unsigned NROW_BITS  = SYS_WIDTH * ARR_WIDTH * WIDTH,
  localparam int unsigned NMAT_BITS  = NROWS * NROW_BITS,
  localparam int unsigned NRIDX_W    = ridx_width(NROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 calc_done_flag,
  input  logic [NMAT_BITS-1:0] in_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NROW_BITS-1:0] out_row,
  output logic [NRIDX_W-1:0]   out_row_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam logic [NRIDX_W-1:0] LAST_IDX = NRIDX_W'(NROWS - 1);

  logic [0:0]                       state_q, state_d;
  logic [NRIDX_W-1:0]               ridx_q, ridx_d;
  logic [NROWS-1:0][NROW_BITS-1:0]  capture_q;
  logic                             done_rise;
  logic                             accept;
  logic                             cap_load;
  logic                             frame_inc;
  logic                             ovr_set;

  ndp_edge_det u_done_edge (
    .clk    (clk),
    .reset  (reset),
    .d      (calc_done_flag),
    .rise_c (done_rise)
  );

  // All beat outputs derive from registered state only
  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q == DRAIN);
  assign out_row_idx = ridx_q;
  assign out_last    = out_valid & (ridx_q == LAST_IDX);
  assign out_row     = capture_q[ridx_q];
  assign accept      = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ridx_q    <= '0;
      capture_q <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      ridx_q  <= ridx_d;
      if (cap_load)  capture_q <= in_c;
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      overrun <= ovr_set | (overrun & ~overrun_clr);
    end
  end

  always_comb begin
    state_d   = state_q;
    ridx_d    = ridx_q;
    cap_load  = 1'b0;
    frame_inc = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_rise) begin
          cap_load = 1'b1;
          ridx_d   = '0;
          state_d  = DRAIN;
        end
      end
      default: begin
        if (accept) begin
          if (out_last) begin
            frame_inc = 1'b1;
            // A result landing exactly on the last accept chains straight into the next drain
            if (done_rise) begin
              cap_load = 1'b1;
              ridx_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            ridx_d = ridx_q + NRIDX_W'(1);
          end
        end
        if (done_rise && !(accept && out_last)) ovr_set = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ndp_result_drain.sv
// Randomized and directed bench for ndp_result_drain against a row-queue reference model.
module tb_ndp_result_drain;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned ARR_HEIGHT = 4;
  localparam int unsigned ARR_WIDTH  = 4;
  localparam int unsigned SYS_HEIGHT = 1;
  localparam int unsigned SYS_WIDTH  = 2;
  localparam int unsigned ROWS       = SYS_HEIGHT * ARR_HEIGHT;
  localparam int unsigned ELEMS      = SYS_WIDTH * ARR_WIDTH;
  localparam int unsigned ROW_BITS   = ELEMS * WIDTH;
  localparam int unsigned MAT_BITS   = ROWS * ROW_BITS;
  localparam int unsigned RIDX_W     = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                calc_done_flag;
  logic [MAT_BITS-1:0] in_c;
  logic                out_valid;
  logic                out_ready;
  logic [ROW_BITS-1:0] out_row;
  logic [RIDX_W-1:0]   out_row_idx;
  logic                out_last;
  logic                busy;
  logic [15:0]         frame_cnt;
  logic                overrun;
  logic                overrun_clr;

  ndp_result_drain #(
    .WIDTH      (WIDTH),
    .ARR_HEIGHT (ARR_HEIGHT),
    .ARR_WIDTH  (ARR_WIDTH),
    .SYS_HEIGHT (SYS_HEIGHT),
    .SYS_WIDTH  (SYS_WIDTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .calc_done_flag (calc_done_flag),
    .in_c           (in_c),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_row        (out_row),
    .out_row_idx    (out_row_idx),
    .out_last       (out_last),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of rows still owed downstream
  typedef struct {
    logic [ROW_BITS-1:0] data;
    int unsigned         idx;
  } beat_t;

  beat_t               exp_q[$];
  logic [15:0]         exp_frames;
  bit                  exp_ovr;
  bit                  done_prev;
  logic [MAT_BITS-1:0] mat;
  int                  n_checks = 0;
  int                  n_fail   = 0;

  task automatic check(input string tag, input logic [ROW_BITS-1:0] act,
                       input logic [ROW_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [MAT_BITS-1:0] uniform(input logic [WIDTH-1:0] base);
    logic [MAT_BITS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int j = 0; j < ELEMS; j++)
        m[r*ROW_BITS + j*WIDTH +: WIDTH] = base + WIDTH'(r);
    return m;
  endfunction

  function automatic logic [MAT_BITS-1:0] random_mat();
    logic [MAT_BITS-1:0] m;
    for (int k = 0; k < MAT_BITS / 32; k++) m[k*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = (exp_q.size() > 0);
    check("out_valid", ROW_BITS'(out_valid), ROW_BITS'(ev));
    check("busy", ROW_BITS'(busy), ROW_BITS'(ev));
    check("frame_cnt", ROW_BITS'(frame_cnt), ROW_BITS'(exp_frames));
    check("overrun", ROW_BITS'(overrun), ROW_BITS'(exp_ovr));
    if (ev) begin
      check("out_row", out_row, exp_q[0].data);
      check("out_row_idx", ROW_BITS'(out_row_idx), ROW_BITS'(exp_q[0].idx));
      check("out_last", ROW_BITS'(out_last), ROW_BITS'(exp_q[0].idx == ROWS - 1));
    end
  endtask

  task automatic model_update();
    bit    rise, set_now;
    beat_t b;
    rise    = calc_done_flag && !done_prev;
    set_now = 1'b0;
    if (exp_q.size() > 0 && out_ready) begin
      if (exp_q[0].idx == ROWS - 1) exp_frames = exp_frames + 16'd1;
      void'(exp_q.pop_front());
    end
    if (rise) begin
      if (exp_q.size() == 0) begin
        for (int r = 0; r < ROWS; r++) begin
          b.data = in_c[r*ROW_BITS +: ROW_BITS];
          b.idx  = r;
          exp_q.push_back(b);
        end
      end else begin
        exp_ovr = 1'b1;
        set_now = 1'b1;
      end
    end
    if (overrun_clr && !set_now) exp_ovr = 1'b0;
    done_prev = calc_done_flag;
  endtask

  // One clock: drive at the falling edge, check, then advance the model past the rising edge
  task automatic step(input bit done, input bit rdy, input bit clr);
    @(negedge clk);
    calc_done_flag = done;
    out_ready      = rdy;
    overrun_clr    = clr;
    in_c           = mat;
    check_outputs();
    model_update();
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_frames = '0;
    exp_ovr    = 1'b0;
    done_prev  = 1'b0;
  endtask

  initial begin
    bit pattern [7];
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset          = 1'b1;
    calc_done_flag = 1'b0;
    out_ready      = 1'b0;
    overrun_clr    = 1'b0;
    mat            = '0;
    in_c           = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", ROW_BITS'(out_valid), '0);
    check("rst_out_row", out_row, '0);
    check("rst_out_idx", ROW_BITS'(out_row_idx), '0);
    check("rst_out_last", ROW_BITS'(out_last), '0);
    check("rst_busy", ROW_BITS'(busy), '0);
    check("rst_frame_cnt", ROW_BITS'(frame_cnt), '0);
    check("rst_overrun", ROW_BITS'(overrun), '0);
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b0);

    // Basic drain
    mat = uniform(16'h3C00);
    step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // Backpressure
    mat = uniform(16'h1000);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, pattern[i], 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Level hold
    mat = uniform(16'h2000);
    repeat (20) step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Overrun while row 1 is presented, then clear
    mat = uniform(16'h3000);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    mat = {(MAT_BITS / 16){16'hBEEF}};
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);

    // Back-to-back: new result coincides with last-beat accept
    mat = uniform(16'h4000);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    mat = uniform(16'h4100);
    step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset while row 2 is presented
    mat = uniform(16'h5000);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_idx", ROW_BITS'(out_row_idx), ROW_BITS'(2));
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", ROW_BITS'(out_valid), '0);
    check("async_rst_busy", ROW_BITS'(busy), '0);
    check("async_rst_frame_cnt", ROW_BITS'(frame_cnt), '0);
    model_reset();
    calc_done_flag = 1'b0;
    out_ready      = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mat = uniform(16'h6000);
    step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) mat = random_mat();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (8) step(1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
